hooked_item_ctrl: RTL and testbench
===================================

// Module: hooked_item_ctrl
// PURPOSE
//  Responder side of the cable grab: one collectible item (gold/rock) on the playfield.
//  Idle at its spawn point until the cable tip collides with it, then rides the cable tip back.
//  When the cable reports it is home, the item is collected: one score pulse is emitted and the item hides.
//  Placed beside the cable mover; its topLeftX/Y feed the item bitmap/draw path; score goes to the score counter.
// PARAMETERS
//  INIT_X          200  spawn top-left X (pixels)
//  INIT_Y          300  spawn top-left Y (pixels)
//  ITEM_VALUE      50   score value reported on collection (8 bit)
//  ITEM_WEIGHT     2    pull weight 0..7 reported while attached (cable speed divider hint)
//  RESPAWN_FRAMES  90   frames hidden before respawn (used only with ITEM_RESPAWN_EN)
// PORTS
//  clk              in   1   system clock
//  resetN           in   1   asynchronous, active-low reset
//  startOfFrame     in   1   one-clk pulse per frame; all position updates and frame counts happen here
//  cable_collision  in   1   cable tip draw overlaps this item's draw request (level, per pixel)
//  cable_home       in   1   cable is back at its swing origin (level)
//  cableTopLeftX    in   11s cable tip top-left X
//  cableTopLeftY    in   11s cable tip top-left Y
//  topLeftX         out  11s item top-left X
//  topLeftY         out  11s item top-left Y
//  item_visible     out  1   item should be drawn
//  item_attached    out  1   item is riding the cable
//  pull_weight      out  3   ITEM_WEIGHT while attached, else 0
//  collected_pulse  out  1   one-clk pulse on collection
//  score_value      out  8   ITEM_VALUE during collected_pulse, else 0
// BEHAVIOUR
//  Reset: state=IDLE; topLeft=(INIT_X,INIT_Y); item_visible=1; item_attached=0; pull_weight=0;
//   collected_pulse=0; score_value=0; offsets=0; respawn counter=0. Reset mid-operation aborts any state.
//  FSM states: IDLE, ATTACHED, COLLECTED, HIDDEN.
//  IDLE: visible, position fixed. cable_collision=1 -> ATTACHED next clk; same clk latch
//   offX=topLeftX-cableTopLeftX, offY=topLeftY-cableTopLeftY (12-bit signed, no saturation).
//  ATTACHED: on each startOfFrame topLeft <= cableTopLeft + off (truncated to 11 bits).
//   cable_collision ignored. cable_home=1 -> COLLECTED next clk (position not updated that clk).
//  COLLECTED: exactly one clk; collected_pulse=1, score_value=ITEM_VALUE; item_visible=0; -> HIDDEN.
//  HIDDEN: item_visible=0, collision and home ignored; behaviour per CONFIGURATION.
//  Outputs registered: item_visible/item_attached/pull_weight reflect current state (1 clk after transition cause).
//  Simultaneous collision+cable_home in IDLE: attach wins; home not sampled until in ATTACHED.
//  cable_home already 1 when entering ATTACHED: collect on the following clk (level sensitive).
//  startOfFrame coinciding with cable_home in ATTACHED: transition wins, no position update.
// CONFIGURATION
//  Macro ITEM_RESPAWN_EN.
//  Defined: HIDDEN counts startOfFrame pulses; after RESPAWN_FRAMES pulses, topLeft <= (INIT_X,INIT_Y),
//   counter cleared, -> IDLE (visible next clk). Counter cleared on HIDDEN entry.
//  Undefined: HIDDEN is terminal until reset; no counter logic synthesized.
// STRUCTURE
//  Package item_pkg: typedef enum logic[1:0] item_state_t {IDLE,ATTACHED,COLLECTED,HIDDEN};
//   typedef logic signed [10:0] coord_t; typedef logic signed [11:0] offset_t.
//  Sub-module frame_countdown (load, startOfFrame enable, done flag), instantiated only under ITEM_RESPAWN_EN.
// TESTING
//  1 Reset release -> topLeft=(200,300), item_visible=1, item_attached=0, collected_pulse=0.
//  2 cable (180,290), collision 1 clk -> item_attached=1, pull_weight=2; cable to (150,250), SOF -> topLeft=(170,260).
//  3 ATTACHED, cable_home=1 -> one clk collected_pulse=1, score_value=50; then item_visible=0, score_value=0.
//  4 Collision and cable_home together in IDLE -> ATTACHED, collected_pulse next clk after, never same clk.
//  5 ITEM_RESPAWN_EN, RESPAWN_FRAMES=3: after collection, 3 SOF pulses -> item_visible=1 at (200,300); w/o macro stays hidden 100 frames.
//  6 resetN low while ATTACHED at (170,260) -> immediate topLeft=(200,300), IDLE, outputs at reset values.

Source files
------------

// File: rtl/hooked_item_ctrl_pkg.sv
// rtl/hooked_item_ctrl_pkg.sv - shared types for the hooked item controller
// Contents:
//   item_state_t  IDLE / ATTACHED / COLLECTED / HIDDEN
//   coord_t       11-bit signed playfield coordinate
//   offset_t      12-bit signed item-to-cable offset
package item_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ATTACHED  = 2'd1,
        COLLECTED = 2'd2,
        HIDDEN    = 2'd3
    } item_state_t;

    typedef logic signed [10:0] coord_t;
    typedef logic signed [11:0] offset_t;

endpackage

// File: rtl/hooked_item_ctrl_if.sv
// rtl/hooked_item_ctrl_if.sv - cable/item signal bundle
// Signals:
//   startOfFrame, cable_collision, cable_home, cableTopLeftX/Y   cable side -> item
//   topLeftX/Y, item_visible, item_attached, pull_weight,
//   collected_pulse, score_value                                item -> draw/score path
// Modports: master (cable/environment side), slave (item controller)
interface hooked_item_ctrl_if;
    import item_pkg::*;

    logic        startOfFrame;
    logic        cable_collision;
    logic        cable_home;
    coord_t      cableTopLeftX;
    coord_t      cableTopLeftY;
    coord_t      topLeftX;
    coord_t      topLeftY;
    logic        item_visible;
    logic        item_attached;
    logic [2:0]  pull_weight;
    logic        collected_pulse;
    logic [7:0]  score_value;

    modport master (
        output startOfFrame, cable_collision, cable_home, cableTopLeftX, cableTopLeftY,
        input  topLeftX, topLeftY, item_visible, item_attached, pull_weight,
               collected_pulse, score_value
    );

    modport slave (
        input  startOfFrame, cable_collision, cable_home, cableTopLeftX, cableTopLeftY,
        output topLeftX, topLeftY, item_visible, item_attached, pull_weight,
               collected_pulse, score_value
    );

endinterface

// File: rtl/hooked_item_ctrl_frame_countdown.sv
// rtl/hooked_item_ctrl_frame_countdown.sv - counts enabled frame pulses up to FRAMES
// Ports:
//   clk, resetN    clock, asynchronous active-low reset
//   load           clear the count
//   startOfFrame   count enable (one pulse per frame)
//   done           high in the cycle of the FRAMES-th enabled pulse; count wraps to 0
// FRAMES must be at least 1.
module frame_countdown #(
    parameter int unsigned FRAMES = 90
) (
    input  logic clk,
    input  logic resetN,
    input  logic load,
    input  logic startOfFrame,
    output logic done
);

    localparam logic [15:0] LAST = FRAMES[15:0] - 16'd1;

    logic [15:0] count;

    assign done = startOfFrame && !load && (count == LAST);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            count <= 16'd0;
        end else if (load || done) begin
            count <= 16'd0;
        end else if (startOfFrame) begin
            count <= count + 16'd1;
        end
    end

endmodule

// File: rtl/hooked_item_ctrl.sv
// rtl/hooked_item_ctrl.sv - collectible item that rides the cable tip home
// Ports:
//   clk, resetN   clock, asynchronous active-low reset
//   bus (slave)   cable inputs in; position, visibility, weight and score pulse out
// Build option: ITEM_RESPAWN_EN - hidden item reappears at its spawn point after
//   RESPAWN_FRAMES frames; without it, a collected item stays hidden until reset.
module hooked_item_ctrl
    import item_pkg::*;
#(
    parameter int          INIT_X         = 200,
    parameter int          INIT_Y         = 300,
    parameter int          ITEM_VALUE     = 50,
    parameter int          ITEM_WEIGHT    = 2,
    parameter int unsigned RESPAWN_FRAMES = 90
) (
    input logic              clk,
    input logic              resetN,
    hooked_item_ctrl_if.slave bus
);

    item_state_t state, state_next;
    coord_t      top_left_x, top_left_y;
    offset_t     off_x, off_y;
    offset_t     ride_x, ride_y;
    logic        visible_q, attached_q, pulse_q;
    logic [2:0]  weight_q;
    logic [7:0]  score_q;

`ifdef ITEM_RESPAWN_EN
    logic respawn_done;

    frame_countdown #(.FRAMES(RESPAWN_FRAMES)) u_respawn (
        .clk          (clk),
        .resetN       (resetN),
        .load         (state == COLLECTED),
        .startOfFrame (bus.startOfFrame && (state == HIDDEN)),
        .done         (respawn_done)
    );
`else
    localparam int unsigned unused_respawn_frames = RESPAWN_FRAMES;
`endif

    // Offsets are kept at 12 bits so any on-screen pair is representable;
    // the sum wraps back to 11 bits on purpose.
    assign ride_x = offset_t'(bus.cableTopLeftX) + off_x;
    assign ride_y = offset_t'(bus.cableTopLeftY) + off_y;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (bus.cable_collision) state_next = ATTACHED;
            ATTACHED:  if (bus.cable_home)      state_next = COLLECTED;
            COLLECTED: state_next = HIDDEN;
            HIDDEN: begin
`ifdef ITEM_RESPAWN_EN
                if (respawn_done) state_next = IDLE;
`endif
            end
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state      <= IDLE;
            top_left_x <= coord_t'(INIT_X);
            top_left_y <= coord_t'(INIT_Y);
            off_x      <= '0;
            off_y      <= '0;
            visible_q  <= 1'b1;
            attached_q <= 1'b0;
            weight_q   <= 3'd0;
            pulse_q    <= 1'b0;
            score_q    <= 8'd0;
        end else begin
            state <= state_next;

            // Status outputs follow the state being entered so they line up with it.
            visible_q  <= (state_next == IDLE) || (state_next == ATTACHED);
            attached_q <= (state_next == ATTACHED);
            weight_q   <= (state_next == ATTACHED) ? 3'(ITEM_WEIGHT) : 3'd0;
            pulse_q    <= (state_next == COLLECTED);
            score_q    <= (state_next == COLLECTED) ? 8'(ITEM_VALUE) : 8'd0;

            case (state)
                IDLE: begin
                    if (bus.cable_collision) begin
                        off_x <= offset_t'(top_left_x) - offset_t'(bus.cableTopLeftX);
                        off_y <= offset_t'(top_left_y) - offset_t'(bus.cableTopLeftY);
                    end
                end
                ATTACHED: begin
                    // Going home takes priority over a frame move in the same clock.
                    if (bus.startOfFrame && !bus.cable_home) begin
                        top_left_x <= coord_t'(ride_x);
                        top_left_y <= coord_t'(ride_y);
                    end
                end
                HIDDEN: begin
`ifdef ITEM_RESPAWN_EN
                    if (respawn_done) begin
                        top_left_x <= coord_t'(INIT_X);
                        top_left_y <= coord_t'(INIT_Y);
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    assign bus.topLeftX        = top_left_x;
    assign bus.topLeftY        = top_left_y;
    assign bus.item_visible    = visible_q;
    assign bus.item_attached   = attached_q;
    assign bus.pull_weight     = weight_q;
    assign bus.collected_pulse = pulse_q;
    assign bus.score_value     = score_q;

endmodule

// File: tb/tb_hooked_item_ctrl.sv
// tb/tb_hooked_item_ctrl.sv - self-checking bench for hooked_item_ctrl
module tb_hooked_item_ctrl;
    import item_pkg::*;

    localparam int INIT_X = 200;
    localparam int INIT_Y = 300;
    localparam int VALUE  = 50;
    localparam int WEIGHT = 2;
    localparam int RF     = 3;

    logic clk = 1'b0;
    logic resetN = 1'b0;
    int   checks = 0;
    int   errors = 0;

    hooked_item_ctrl_if bus();

    hooked_item_ctrl #(
        .INIT_X(INIT_X), .INIT_Y(INIT_Y), .ITEM_VALUE(VALUE),
        .ITEM_WEIGHT(WEIGHT), .RESPAWN_FRAMES(RF)
    ) dut (
        .clk(clk),
        .resetN(resetN),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int rst;
        int sof, coll, home, cx, cy;
        int vis, att, pw, pulse, score, x, y;
    } vec_t;

    vec_t vecs[9];

    // Reference model: the item as a position plus a few plain facts about it.
    int m_x, m_y, m_offx, m_offy, m_hidden_sof;
    bit m_on_cable, m_gone, m_just_scored;

    function automatic int wrap11(input int v);
        int r;
        r = v & 2047;
        if (r >= 1024) r = r - 2048;
        return r;
    endfunction

    function automatic int wrap12(input int v);
        int r;
        r = v & 4095;
        if (r >= 2048) r = r - 4096;
        return r;
    endfunction

    task automatic model_reset();
        m_x = INIT_X; m_y = INIT_Y; m_offx = 0; m_offy = 0; m_hidden_sof = 0;
        m_on_cable = 0; m_gone = 0; m_just_scored = 0;
    endtask

    task automatic model_step(input int sof, input int coll, input int home,
                              input int cx, input int cy);
        if (m_just_scored) begin
            m_just_scored = 0;
            m_gone = 1;
            m_hidden_sof = 0;
        end else if (m_gone) begin
`ifdef ITEM_RESPAWN_EN
            if (sof != 0) begin
                m_hidden_sof++;
                if (m_hidden_sof == RF) begin
                    m_gone = 0;
                    m_x = INIT_X;
                    m_y = INIT_Y;
                end
            end
`endif
        end else if (m_on_cable) begin
            if (home != 0) begin
                m_on_cable = 0;
                m_just_scored = 1;
            end else if (sof != 0) begin
                m_x = wrap11(cx + m_offx);
                m_y = wrap11(cy + m_offy);
            end
        end else if (coll != 0) begin
            m_on_cable = 1;
            m_offx = wrap12(m_x - cx);
            m_offy = wrap12(m_y - cy);
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic drive(input int sof, input int coll, input int home,
                         input int cx, input int cy);
        bus.startOfFrame    = (sof != 0);
        bus.cable_collision = (coll != 0);
        bus.cable_home      = (home != 0);
        bus.cableTopLeftX   = coord_t'(cx);
        bus.cableTopLeftY   = coord_t'(cy);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0);
        resetN = 1'b0;
        tick();
        resetN = 1'b1;
        model_reset();
    endtask

    task automatic chk_all(input string tag, input int vis, input int att, input int pw,
                           input int pulse, input int score, input int x, input int y);
        int ax, ay;
        ax = bus.topLeftX;
        ay = bus.topLeftY;
        chk({tag, ".visible"},  int'(bus.item_visible),    vis);
        chk({tag, ".attached"}, int'(bus.item_attached),   att);
        chk({tag, ".weight"},   int'(bus.pull_weight),     pw);
        chk({tag, ".pulse"},    int'(bus.collected_pulse), pulse);
        chk({tag, ".score"},    int'(bus.score_value),     score);
        chk({tag, ".x"},        ax, x);
        chk({tag, ".y"},        ay, y);
    endtask

    initial begin
        int cx, cy, sof, coll, home, bad;

        //           rst sof coll home  cx   cy  vis att pw pul  sc    x    y
        vecs[0] = '{ 1,  0,  1,  0,  180, 290,  1,  1,  2, 0,   0, 200, 300};
        vecs[1] = '{ 0,  0,  1,  0,    0,   0,  1,  1,  2, 0,   0, 200, 300};
        vecs[2] = '{ 0,  1,  0,  0,  150, 250,  1,  1,  2, 0,   0, 170, 260};
        vecs[3] = '{ 0,  0,  0,  1,  150, 250,  0,  0,  0, 1,  50, 170, 260};
        vecs[4] = '{ 0,  0,  0,  0,  150, 250,  0,  0,  0, 0,   0, 170, 260};
        vecs[5] = '{ 0,  0,  1,  0,   10,  10,  0,  0,  0, 0,   0, 170, 260};
        vecs[6] = '{ 1,  0,  1,  1,  100, 100,  1,  1,  2, 0,   0, 200, 300};
        vecs[7] = '{ 0,  1,  0,  1,   50,  60,  0,  0,  0, 1,  50, 200, 300};
        vecs[8] = '{ 0,  0,  0,  0,   50,  60,  0,  0,  0, 0,   0, 200, 300};

        drive(0, 0, 0, 0, 0);
        resetN = 1'b0;
        tick();
        tick();
        resetN = 1'b1;
        #2;
        chk_all("reset", 1, 0, 0, 0, 0, INIT_X, INIT_Y);

        for (int i = 0; i < 9; i++) begin
            if (vecs[i].rst != 0) do_reset();
            drive(vecs[i].sof, vecs[i].coll, vecs[i].home, vecs[i].cx, vecs[i].cy);
            tick();
            chk_all($sformatf("vec%0d", i), vecs[i].vis, vecs[i].att, vecs[i].pw,
                    vecs[i].pulse, vecs[i].score, vecs[i].x, vecs[i].y);
        end

        // Item is hidden after vecs[8]: respawn or stay hidden.
`ifdef ITEM_RESPAWN_EN
        for (int i = 1; i <= RF; i++) begin
            drive(1, 0, 0, 0, 0);
            tick();
            chk($sformatf("respawn_sof%0d.visible", i), int'(bus.item_visible), (i == RF) ? 1 : 0);
        end
        drive(0, 0, 0, 0, 0);
        tick();
        chk_all("respawned", 1, 0, 0, 0, 0, INIT_X, INIT_Y);
`else
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            drive(1, 0, 0, 0, 0);
            tick();
            drive(0, 0, 0, 0, 0);
            tick();
            if (bus.item_visible !== 1'b0) bad++;
        end
        chk("hidden_100_frames.visible_count", bad, 0);
`endif

        // Asynchronous reset while attached.
        do_reset();
        drive(0, 1, 0, 180, 290);
        tick();
        drive(1, 0, 0, 150, 250);
        tick();
        drive(0, 0, 0, 150, 250);
        chk_all("pre_async", 1, 1, 2, 0, 0, 170, 260);
        #3;
        resetN = 1'b0;
        #1;
        chk_all("async_reset", 1, 0, 0, 0, 0, INIT_X, INIT_Y);
        tick();
        resetN = 1'b1;
        model_reset();

        // Randomized run against the reference model.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 249) == 0) do_reset();
            sof  = ($urandom_range(0, 3) == 0) ? 1 : 0;
            coll = ($urandom_range(0, 7) == 0) ? 1 : 0;
            home = ($urandom_range(0, 9) == 0) ? 1 : 0;
            cx   = int'($urandom_range(0, 2047)) - 1024;
            cy   = int'($urandom_range(0, 2047)) - 1024;
            drive(sof, coll, home, cx, cy);
            tick();
            model_step(sof, coll, home, cx, cy);
            chk_all($sformatf("rnd%0d", n), m_gone || m_just_scored ? 0 : 1,
                    int'(m_on_cable), m_on_cable ? WEIGHT : 0, int'(m_just_scored),
                    m_just_scored ? VALUE : 0, m_x, m_y);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
